xorshift_checker: RTL and testbench
===================================

Name: xorshift_checker

Overview:
- Receiving end of the cpu data interface (data_vld/data/transactions_done).
- Independently regenerates the xorshift64* sequence that a given cpu instance emits, using an iterative one-round-per-cycle engine.
- Buffers incoming samples in a small FIFO, compares each sample against its expected value, and reports counts and the first mismatch.
- One instance per cpu, placed beside it in the testbench top.

Parameters:
- CPU_INDEX, 0, selects the seed: 64'hdeadbeefdeadbeef + CPU_INDEX (mod 2^64).
- TRANSACTION_NB, 1000, number of samples expected; must be >= 1.
- ITERATIONS, 20, xorshift64* rounds per transaction; must be >= 1 (elaboration-time check).
- FIFO_DEPTH, 4, input buffer entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- data_vld  input  1  sample valid, one cycle per sample
- data  input  64  sample value
- transactions_done  input  1  producer finished (level)
- check_done  output  1  checking finished (sticky until rst)
- pass  output  1  check_done and no error of any kind
- rx_cnt  output  32  samples compared
- mismatch_cnt  output  32  samples that differed from expected
- overflow  output  1  sticky: sample dropped because the FIFO was full
- underrun  output  1  sticky: producer done before TRANSACTION_NB samples
- extra  output  1  sticky: data_vld seen after check_done
- first_err_idx  output  32  rx_cnt value (0-based) of the first mismatch
- first_err_data  output  64  received value at the first mismatch
- first_err_exp  output  64  expected value at the first mismatch

Behaviour:
- Reset: all outputs 0. FIFO emptied. Engine x = seed, iter_cnt = 0, state COMPUTE.
- Round (64-bit wrap):
  - x ^= x>>12
  - x ^= x<<25
  - x ^= x>>27
  - x = low 64 bits of x*64'h5821657736338717
- E_0 = seed; E_k = ITERATIONS rounds applied to E_{k-1}. Sample k (1-based) must equal E_k.
- FIFO push:
  - Push when data_vld=1 and state != DONE.
  - If full (registered count == FIFO_DEPTH) and no pop this cycle: sample dropped, overflow<=1.
  - Push and pop in the same cycle while full: push accepted.
- States:
  - COMPUTE: one round per cycle, iter_cnt++. After the ITERATIONS-th round, go to WAIT with expected = x.
  - WAIT:
    - FIFO non-empty -> COMPARE.
    - Else if transactions_done=1 -> underrun<=1, go to DONE.
  - COMPARE (1 cycle):
    - Pop the head and increment rx_cnt.
    - If head != expected: increment mismatch_cnt. If this is the first mismatch, latch first_err_idx = old rx_cnt, first_err_data, first_err_exp.
    - If new rx_cnt == TRANSACTION_NB -> DONE. Else COMPUTE with x = expected, iter_cnt = 0; the sequence continues from the expected value, never from the received one.
  - DONE: check_done=1. pass = (mismatch_cnt==0 && !overflow && !underrun && !extra), registered. Any data_vld in DONE -> extra<=1 (pass drops next cycle).
- Samples arriving during COMPUTE wait in the FIFO; there is no back-pressure on the producer.
- Latency: sample accepted at edge N with empty FIFO and state WAIT -> COMPARE in cycle N+1 -> rx_cnt/mismatch_cnt visible after edge N+2.
- Minimum per-transaction checker throughput: ITERATIONS+2 cycles.
- Counters saturate at 2^32-1.
- rst mid-operation: everything returns to the reset state on the next edge; a data_vld in the reset cycle is ignored.

Test Plan:
- CPU_INDEX=0, ITERATIONS=1, TRANSACTION_NB=3, bench model drives E_1..E_3 with 10-cycle gaps -> rx_cnt=3, mismatch_cnt=0, check_done=1, pass=1.
- Same setup, sample 2 driven as E_2^64'h1 -> mismatch_cnt=1, first_err_idx=1, first_err_data=E_2^1, first_err_exp=E_2. Sample 3 = E_3 still matches; pass=0.
- ITERATIONS=20, FIFO_DEPTH=4, 5 correct samples on consecutive cycles -> 4 buffered, 5th dropped (if no pop yet), overflow=1, pass=0.
- TRANSACTION_NB=5, only 2 samples sent, then transactions_done=1 -> underrun=1, check_done=1, rx_cnt=2, pass=0.
- After pass=1, one extra data_vld -> extra=1, pass=0 next cycle, rx_cnt unchanged.
- rst asserted mid-COMPUTE after 1 sample checked -> all outputs 0. Replaying E_1..E_3 from scratch -> pass=1.

Source files
------------

// File: rtl/xorshift_checker.sv
// Receive-side checker: regenerates the xorshift64* stream of one cpu and
// compares every buffered sample against it, reporting counts and first error.
module xorshift_checker #(
  parameter int unsigned CPU_INDEX      = 0,
  parameter int unsigned TRANSACTION_NB = 1000,
  parameter int unsigned ITERATIONS     = 20,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_vld,
  input  logic [63:0] data,
  input  logic        transactions_done,
  output logic        check_done,
  output logic        pass,
  output logic [31:0] rx_cnt,
  output logic [31:0] mismatch_cnt,
  output logic        overflow,
  output logic        underrun,
  output logic        extra,
  output logic [31:0] first_err_idx,
  output logic [63:0] first_err_data,
  output logic [63:0] first_err_exp
);

  localparam logic [63:0] SEED = 64'hdeadbeefdeadbeef + 64'(CPU_INDEX);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  if (ITERATIONS < 1 || TRANSACTION_NB < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("xorshift_checker: illegal parameter value");
  end

  typedef enum logic [1:0] {
    COMPUTE = 2'd0,
    WAIT    = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [63:0] xs_round(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v >> 12);
    t = t ^ (t << 25);
    t = t ^ (t >> 27);
    return t * 64'h5821657736338717;
  endfunction

  state_t      state_q, state_d;
  logic [63:0] x_q, x_d;
  logic [31:0] iter_q, iter_d;
  logic [63:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] mm_q, mm_d;
  logic        ovf_q, ovf_d;
  logic        und_q, und_d;
  logic        ext_q, ext_d;
  logic        pass_q, pass_d;
  logic [31:0] fidx_q, fidx_d;
  logic [63:0] fdat_q, fdat_d;
  logic [63:0] fexp_q, fexp_d;
  logic        push, push_ok, pop, full;
  logic [63:0] head;

  assign head = mem_q[rd_ptr_q];
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop  = (state_q == COMPARE);
  assign push = data_vld && (state_q != DONE);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    iter_d   = iter_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
    rx_d     = rx_q;
    mm_d     = mm_q;
    ovf_d    = ovf_q;
    und_d    = und_q;
    ext_d    = ext_q;
    fidx_d   = fidx_q;
    fdat_d   = fdat_q;
    fexp_d   = fexp_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (push && !push_ok) ovf_d = 1'b1;
    if (state_q == DONE && data_vld) ext_d = 1'b1;
    unique case (state_q)
      COMPUTE: begin
        x_d    = xs_round(x_q);
        iter_d = iter_q + 32'd1;
        if (iter_q == 32'(ITERATIONS - 1)) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          state_d = COMPARE;
        end else if (transactions_done) begin
          und_d   = 1'b1;
          state_d = DONE;
        end
      end
      COMPARE: begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (rx_q != '1) rx_d = rx_q + 32'd1;
        if (head != x_q) begin
          if (mm_q != '1) mm_d = mm_q + 32'd1;
          if (mm_q == '0) begin
            fidx_d = rx_q;
            fdat_d = head;
            fexp_d = x_q;
          end
        end
        // The stream resumes from the expected value held in x_q.
        if (rx_d == 32'(TRANSACTION_NB)) begin
          state_d = DONE;
        end else begin
          state_d = COMPUTE;
          iter_d  = '0;
        end
      end
      DONE: ;
    endcase
    pass_d = (state_d == DONE) && (mm_d == '0) &&
             !ovf_d && !und_d && !ext_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COMPUTE;
      x_q      <= SEED;
      iter_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rx_q     <= '0;
      mm_q     <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      ext_q    <= 1'b0;
      pass_q   <= 1'b0;
      fidx_q   <= '0;
      fdat_q   <= '0;
      fexp_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      iter_q   <= iter_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      mm_q     <= mm_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      ext_q    <= ext_d;
      pass_q   <= pass_d;
      fidx_q   <= fidx_d;
      fdat_q   <= fdat_d;
      fexp_q   <= fexp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= data;
  end

  assign check_done     = (state_q == DONE);
  assign pass           = pass_q;
  assign rx_cnt         = rx_q;
  assign mismatch_cnt   = mm_q;
  assign overflow       = ovf_q;
  assign underrun       = und_q;
  assign extra          = ext_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdat_q;
  assign first_err_exp  = fexp_q;

endmodule

// File: tb/tb_xorshift_checker.sv
// Bench for xorshift_checker: two instances (fast and slow engines) driven
// with directed steps and random gaps/data against a reference stream model.
module tb_xorshift_checker;

  localparam logic [63:0] BASE = 64'hdeadbeefdeadbeef;
  localparam int unsigned IT0 = 1;
  localparam int unsigned IT1 = 20;
  localparam logic [63:0] SEED0 = BASE;
  localparam logic [63:0] SEED1 = BASE + 64'd5;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        vld [2];
  logic [63:0] dat [2];
  logic        tdone [2];
  logic        check_done [2];
  logic        pass [2];
  logic [31:0] rx_cnt [2];
  logic [31:0] mm_cnt [2];
  logic        overflow [2];
  logic        underrun [2];
  logic        extra [2];
  logic [31:0] fidx [2];
  logic [63:0] fdata [2];
  logic [63:0] fexp [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xorshift_checker #(
    .CPU_INDEX(0), .TRANSACTION_NB(3), .ITERATIONS(IT0), .FIFO_DEPTH(4)
  ) u_dut0 (
    .clk(clk), .rst(rst[0]), .data_vld(vld[0]), .data(dat[0]),
    .transactions_done(tdone[0]), .check_done(check_done[0]),
    .pass(pass[0]), .rx_cnt(rx_cnt[0]), .mismatch_cnt(mm_cnt[0]),
    .overflow(overflow[0]), .underrun(underrun[0]), .extra(extra[0]),
    .first_err_idx(fidx[0]), .first_err_data(fdata[0]),
    .first_err_exp(fexp[0])
  );

  xorshift_checker #(
    .CPU_INDEX(5), .TRANSACTION_NB(5), .ITERATIONS(IT1), .FIFO_DEPTH(4)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]), .data_vld(vld[1]), .data(dat[1]),
    .transactions_done(tdone[1]), .check_done(check_done[1]),
    .pass(pass[1]), .rx_cnt(rx_cnt[1]), .mismatch_cnt(mm_cnt[1]),
    .overflow(overflow[1]), .underrun(underrun[1]), .extra(extra[1]),
    .first_err_idx(fidx[1]), .first_err_data(fdata[1]),
    .first_err_exp(fexp[1])
  );

  // Reference: the k-th value of the stream, straight from the round rules.
  function automatic logic [63:0] ref_e(input logic [63:0] seed,
                                        input int unsigned iters,
                                        input int k);
    logic [63:0] x;
    x = seed;
    for (int n = 0; n < k * int'(iters); n++) begin
      x = x ^ (x >> 12);
      x = x ^ (x << 25);
      x = x ^ (x >> 27);
      x = x * 64'h5821657736338717;
    end
    return x;
  endfunction

  function automatic logic [63:0] e0(input int k);
    return ref_e(SEED0, IT0, k);
  endfunction

  function automatic logic [63:0] e1(input int k);
    return ref_e(SEED1, IT1, k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    vld[i] = 1'b0;
    tdone[i] = 1'b0;
    step(2);
    rst[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [63:0] v);
    vld[i] = 1'b1;
    dat[i] = v;
    step();
    vld[i] = 1'b0;
    dat[i] = $urandom();
  endtask

  task automatic chk_zero(input int i, input string tag);
    logic [63:0] any;
    any = {63'd0, check_done[i]} | {63'd0, pass[i]} |
          {32'd0, rx_cnt[i]} | {32'd0, mm_cnt[i]} |
          {63'd0, overflow[i]} | {63'd0, underrun[i]} |
          {63'd0, extra[i]} | {32'd0, fidx[i]} | fdata[i] | fexp[i];
    chk(tag, any, 64'd0);
  endtask

  task automatic status(input int i, input string tag,
                        input logic [31:0] rx, input logic [31:0] mm,
                        input logic done, input logic ok);
    chk({tag, "_rx"}, {32'd0, rx_cnt[i]}, {32'd0, rx});
    chk({tag, "_mm"}, {32'd0, mm_cnt[i]}, {32'd0, mm});
    chk({tag, "_done"}, {63'd0, check_done[i]}, {63'd0, done});
    chk({tag, "_pass"}, {63'd0, pass[i]}, {63'd0, ok});
  endtask

  initial begin
    logic [63:0] mask;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      vld[i] = 1'b0;
      dat[i] = '0;
      tdone[i] = 1'b0;
    end
    step(3);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Clean run with latency check on the first sample
    step($urandom_range(3, 6));
    send(0, e0(1));
    chk("lat_n", {32'd0, rx_cnt[0]}, 64'd0);
    step();
    chk("lat_n1", {32'd0, rx_cnt[0]}, 64'd0);
    step();
    chk("lat_n2", {32'd0, rx_cnt[0]}, 64'd1);
    step(10);
    send(0, e0(2));
    step(10);
    send(0, e0(3));
    step(5);
    status(0, "clean", 32'd3, 32'd0, 1'b1, 1'b1);

    // Sample after completion
    send(0, $urandom());
    step();
    chk("extra_flag", {63'd0, extra[0]}, 64'd1);
    status(0, "extra", 32'd3, 32'd0, 1'b1, 1'b0);

    // Single-bit corruption of sample 2
    do_reset(0);
    chk_zero(0, "reset_b");
    mask = 64'd1 << $urandom_range(0, 63);
    step(3);
    send(0, e0(1));
    step(10);
    send(0, e0(2) ^ mask);
    step(10);
    send(0, e0(3));
    step(5);
    status(0, "mism", 32'd3, 32'd1, 1'b1, 1'b0);
    chk("mism_idx", {32'd0, fidx[0]}, 64'd1);
    chk("mism_data", fdata[0], e0(2) ^ mask);
    chk("mism_exp", fexp[0], e0(2));

    // Reset while the engine computes, then replay
    do_reset(0);
    step(3);
    send(0, e0(1));
    step(2);
    chk("mid_rx", {32'd0, rx_cnt[0]}, 64'd1);
    rst[0] = 1'b1;
    vld[0] = 1'b1;
    dat[0] = e0(1);
    step();
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    chk_zero(0, "mid_reset");
    for (int k = 1; k <= 3; k++) begin
      step($urandom_range(3, 12));
      send(0, e0(k));
    end
    step(5);
    status(0, "replay", 32'd3, 32'd0, 1'b1, 1'b1);

    // Burst of five while the slow engine is still computing
    do_reset(1);
    for (int k = 1; k <= 5; k++) send(1, e1(k));
    chk("ovf_flag", {63'd0, overflow[1]}, 64'd1);
    step(140);
    status(1, "ovf", 32'd4, 32'd0, 1'b0, 1'b0);
    tdone[1] = 1'b1;
    step(3);
    tdone[1] = 1'b0;
    chk("ovf_und", {63'd0, underrun[1]}, 64'd1);
    status(1, "ovf_end", 32'd4, 32'd0, 1'b1, 1'b0);

    // Producer stops early
    do_reset(1);
    send(1, e1(1));
    step(25);
    send(1, e1(2));
    step(60);
    chk("und_pre", {63'd0, check_done[1]}, 64'd0);
    tdone[1] = 1'b1;
    step(3);
    tdone[1] = 1'b0;
    chk("und_flag", {63'd0, underrun[1]}, 64'd1);
    chk("und_ovf", {63'd0, overflow[1]}, 64'd0);
    status(1, "und", 32'd2, 32'd0, 1'b1, 1'b0);

    // Randomly spaced clean run on the slow engine
    do_reset(1);
    for (int k = 1; k <= 5; k++) begin
      step($urandom_range(10, 30));
      send(1, e1(k));
    end
    step(130);
    chk("rand_ovf", {63'd0, overflow[1]}, 64'd0);
    status(1, "rand", 32'd5, 32'd0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
